// File: rtl/row_scan_scheduler_pkg.sv
// Shared definitions for the LED panel row scan scheduler: state encodings,
// default panel geometry and a small width helper.
package row_scan_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRIME = 3'd1,
        ST_WAIT  = 3'd2,
        ST_BLANK = 3'd3,
        ST_LATCH = 3'd4,
        ST_SHOW  = 3'd5,
        ST_DRAIN = 3'd6
    } scan_state_e;

    localparam int DEF_NUM_ROWS     = 16;
    localparam int DEF_NUM_PLANES   = 4;
    localparam int DEF_BASE_DWELL   = 256;
    localparam int DEF_BLANK_CYCLES = 8;

    // Index width that never collapses to zero bits for a count of 1.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/row_scan_scheduler_if.sv
// Scheduler <-> serializer / panel bundle. master = scheduler side.
interface row_scan_scheduler_if #(
    parameter int NUM_ROWS   = row_scan_scheduler_pkg::DEF_NUM_ROWS,
    parameter int NUM_PLANES = row_scan_scheduler_pkg::DEF_NUM_PLANES
);
    localparam int ROW_W   = row_scan_scheduler_pkg::idx_w(NUM_ROWS);
    localparam int PLANE_W = row_scan_scheduler_pkg::idx_w(NUM_PLANES);

    logic                enable;
    logic                shift_start;
    logic [ROW_W-1:0]    shift_row;
    logic [PLANE_W-1:0]  shift_plane;
    logic                shift_done;
    logic                latch_enable;
    logic                output_enable_n;
    logic [NUM_ROWS-1:0] row_select_n;
    logic                frame_start;
    logic                underrun;
    logic [2:0]          state_out;

    modport master (
        input  enable, shift_done,
        output shift_start, shift_row, shift_plane, latch_enable, output_enable_n,
               row_select_n, frame_start, underrun, state_out
    );

    modport slave (
        output enable, shift_done,
        input  shift_start, shift_row, shift_plane, latch_enable, output_enable_n,
               row_select_n, frame_start, underrun, state_out
    );
endinterface

// File: rtl/row_scan_scheduler_dwell_timer.sv
// Loadable down-counter with a zero flag; times both the blanking gap and
// the per-plane display dwell. A load of N-1 gives N cycles ending on zero.
module row_scan_scheduler_dwell_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);
    logic [W-1:0] count_q;

    // Load wins; otherwise count down and park at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)               count_q <= '0;
        else if (load)           count_q <= load_val;
        else if (count_q != '0)  count_q <= count_q - 1'b1;
    end

    assign zero = (count_q == '0);
endmodule

// File: rtl/row_scan_scheduler.sv
// LED panel row scan scheduler: orders (row, plane) shifts, blanks, latches,
// selects the row and times BCM dwell, overlapping the next shift with the
// current display. All panel/serializer outputs come straight from registers.
module row_scan_scheduler
    import row_scan_scheduler_pkg::*;
#(
    parameter int NUM_ROWS     = DEF_NUM_ROWS,
    parameter int NUM_PLANES   = DEF_NUM_PLANES,
    parameter int BASE_DWELL   = DEF_BASE_DWELL,
    parameter int BLANK_CYCLES = DEF_BLANK_CYCLES
) (
    input  logic                 clk,
    input  logic                 reset,
    row_scan_scheduler_if.master bus
);
    localparam int ROW_W   = idx_w(NUM_ROWS);
    localparam int PLANE_W = idx_w(NUM_PLANES);
    localparam int DWELL_W = $clog2(BASE_DWELL << (NUM_PLANES - 1)) + 1;
    localparam int BLANK_W = $clog2(BLANK_CYCLES) + 1;
    localparam int TMR_W   = (DWELL_W > BLANK_W) ? DWELL_W : BLANK_W;

    scan_state_e state_q, state_d;

    // ptr = next pair to shift, pend = pair shifted and awaiting latch,
    // disp = pair currently latched into the panel.
    logic [ROW_W-1:0]   ptr_row, pend_row, disp_row, nxt_row;
    logic [PLANE_W-1:0] ptr_plane, pend_plane, disp_plane, nxt_plane;

    logic shift_issued;   // SHOW entry issued a shift for the next pair
    logic done_flag;      // that shift has already completed
    logic ur_seen;        // underrun already reported for this SHOW

    logic             tmr_load, tmr_zero;
    logic [TMR_W-1:0] tmr_val;
    logic             show_entry, blank_entry;

    logic                shift_start_d, latch_d, oe_n_d, frame_start_d, underrun_d;
    logic [NUM_ROWS-1:0] row_sel_d;

    logic                shift_start_q, latch_q, oe_n_q, frame_start_q, underrun_q;
    logic [NUM_ROWS-1:0] row_sel_q;
    logic [ROW_W-1:0]    shift_row_q;
    logic [PLANE_W-1:0]  shift_plane_q;

    assign show_entry  = (state_d == ST_SHOW)  && (state_q != ST_SHOW);
    assign blank_entry = (state_d == ST_BLANK) && (state_q != ST_BLANK);
    assign tmr_load    = show_entry || blank_entry;
    assign tmr_val     = show_entry ? ((TMR_W'(BASE_DWELL) << disp_plane) - TMR_W'(1))
                                    : TMR_W'(BLANK_CYCLES - 1);

    row_scan_scheduler_dwell_timer #(.W(TMR_W)) u_dwell_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next state; shift_done only matters in WAIT and SHOW.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (bus.enable) state_d = ST_PRIME;
            ST_PRIME: state_d = ST_WAIT;
            ST_WAIT:  if (bus.shift_done) state_d = ST_BLANK;
            ST_BLANK: if (tmr_zero) state_d = ST_LATCH;
            ST_LATCH: state_d = ST_SHOW;
            ST_SHOW: begin
                if (tmr_zero) begin
                    if (!shift_issued)                         state_d = ST_DRAIN;
                    else if (done_flag || bus.shift_done)      state_d = ST_BLANK;
                end
            end
            ST_DRAIN: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output next values, aligned so the registered outputs track state_q.
    always_comb begin
        shift_start_d = (state_d == ST_PRIME) || (show_entry && bus.enable);
        latch_d       = (state_d == ST_LATCH);
        oe_n_d        = (state_d != ST_SHOW);
        frame_start_d = latch_d && (pend_row == '0) && (pend_plane == '0);
        underrun_d    = (state_q == ST_SHOW) && tmr_zero && shift_issued &&
                        !done_flag && !bus.shift_done && !ur_seen;
        row_sel_d     = row_sel_q;
        if (show_entry)
            row_sel_d = ~(NUM_ROWS'(1) << disp_row);
        else if (state_d == ST_IDLE || state_d == ST_DRAIN)
            row_sel_d = '1;
    end

    // Scan order successor: plane first, then row, wrapping to (0,0).
    always_comb begin
        nxt_row   = ptr_row;
        nxt_plane = ptr_plane + 1'b1;
        if (ptr_plane == PLANE_W'(NUM_PLANES - 1)) begin
            nxt_plane = '0;
            nxt_row   = (ptr_row == ROW_W'(NUM_ROWS - 1)) ? '0 : ptr_row + 1'b1;
        end
    end

    // Pair pointers: advance on each shift, snapshot on latch, rewind on drain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_row  <= '0; ptr_plane  <= '0;
            pend_row <= '0; pend_plane <= '0;
            disp_row <= '0; disp_plane <= '0;
        end else begin
            if (shift_start_d) begin
                pend_row  <= ptr_row;
                pend_plane <= ptr_plane;
                ptr_row   <= nxt_row;
                ptr_plane <= nxt_plane;
            end else if (state_q == ST_DRAIN) begin
                ptr_row   <= '0;
                ptr_plane <= '0;
            end
            if (latch_d) begin
                disp_row   <= pend_row;
                disp_plane <= pend_plane;
            end
        end
    end

    // Per-SHOW bookkeeping, cleared on every SHOW entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_issued <= 1'b0;
            done_flag    <= 1'b0;
            ur_seen      <= 1'b0;
        end else if (show_entry) begin
            shift_issued <= bus.enable;
            done_flag    <= 1'b0;
            ur_seen      <= 1'b0;
        end else begin
            if (state_q == ST_SHOW && bus.shift_done) done_flag <= 1'b1;
            if (underrun_d)                           ur_seen   <= 1'b1;
        end
    end

    // Output registers; reset puts the panel dark with no row selected.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_start_q <= 1'b0;
            shift_row_q   <= '0;
            shift_plane_q <= '0;
            latch_q       <= 1'b0;
            oe_n_q        <= 1'b1;
            row_sel_q     <= '1;
            frame_start_q <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            shift_start_q <= shift_start_d;
            if (shift_start_d) begin
                shift_row_q   <= ptr_row;
                shift_plane_q <= ptr_plane;
            end
            latch_q       <= latch_d;
            oe_n_q        <= oe_n_d;
            row_sel_q     <= row_sel_d;
            frame_start_q <= frame_start_d;
            underrun_q    <= underrun_d;
        end
    end

    assign bus.shift_start     = shift_start_q;
    assign bus.shift_row       = shift_row_q;
    assign bus.shift_plane     = shift_plane_q;
    assign bus.latch_enable    = latch_q;
    assign bus.output_enable_n = oe_n_q;
    assign bus.row_select_n    = row_sel_q;
    assign bus.frame_start     = frame_start_q;
    assign bus.underrun        = underrun_q;
    assign bus.state_out       = state_q;
endmodule
